// File: rtl/mips16_muldiv_unit_if.sv
// Handshake/data bundle between the mips16 core and its HI/LO multiply/divide unit.
// master = core side (drives start/op/operands/hi_lo_sl), slave = muldiv unit.
interface mips16_muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_lo_sl;
    logic             instr_stall_sl;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;
    logic             div0_err;

    modport master (
        output start, op, src_a, src_b, hi_lo_sl,
        input  instr_stall_sl, busy, ready,
        input  hi, lo, result, div0_err
    );

    modport slave (
        input  start, op, src_a, src_b, hi_lo_sl,
        output instr_stall_sl, busy, ready,
        output hi, lo, result, div0_err
    );
endinterface

// File: rtl/mips16_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU,
// one bit per cycle. Ports: clock, reset_n (async low), bus (slave modport):
//   start/op/src_a/src_b/hi_lo_sl in; instr_stall_sl/busy/ready/hi/lo/result/div0_err out.
// Optional MULDIV_DIV0_TRAP_EN: zero divisor skips the iterations and flags div0_err.
module mips16_muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic                 clock,
    input logic                 reset_n,
    mips16_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               sa_q;

    logic               is_div;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_nx;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_nx;
    logic [WIDTH-1:0]   lo_nx;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    assign a_mag     = a_neg ? -a_q : a_q;
    assign b_mag     = b_neg ? -b_q : b_q;
    assign last      = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_DIV0_TRAP_EN
    logic b_zero;
    logic div0_q;

    assign b_zero = (b_q == '0);
`endif

    // Multiply: p = {partial, multiplier}; add m into the upper half
    // when the multiplier LSB is set, then shift right keeping the carry.
    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]};
        if (p_q[0])
            mul_sum = mul_sum + {1'b0, m_q};
        mul_nx = {mul_sum, p_q[WIDTH-1:1]};
    end

    // Divide: p = {remainder, dividend}; shift one dividend bit into
    // the remainder, subtract the divisor if it fits, shift in the quotient bit.
    always_comb begin
        div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        if (div_diff[WIDTH])
            div_nx = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        else
            div_nx = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction on the final iteration's result.
    always_comb begin
        prod_fix = neg_q ? -mul_nx : mul_nx;
        quo_fix  = neg_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
        rem_fix  = sa_q ? -div_nx[2*WIDTH-1:WIDTH]
                        : div_nx[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi_nx = rem_fix;
            lo_nx = quo_fix;
        end else begin
            hi_nx = prod_fix[2*WIDTH-1:WIDTH];
            lo_nx = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nx = S_PREP;
`ifdef MULDIV_DIV0_TRAP_EN
            S_PREP: state_nx = (is_div && b_zero) ? S_DONE : S_RUN;
`else
            S_PREP: state_nx = S_RUN;
`endif
            S_RUN:  if (last) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.ready = 1'b0;
        unique case (state)
            S_PREP,
            S_RUN:   bus.busy = 1'b1;
            S_DONE:  bus.ready = 1'b1;
            default: ;
        endcase
        bus.instr_stall_sl = bus.busy | ((state == S_IDLE) & bus.start);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef MULDIV_DIV0_TRAP_EN
            div0_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.src_a;
                        b_q  <= bus.src_b;
`ifdef MULDIV_DIV0_TRAP_EN
                        div0_q <= 1'b0;
`endif
                    end
                end
                S_PREP: begin
                    neg_q <= a_neg ^ b_neg;
                    sa_q  <= a_neg;
                    cnt_q <= '0;
                    if (is_div) begin
                        p_q <= {{WIDTH{1'b0}}, a_mag};
                        m_q <= b_mag;
                    end else begin
                        p_q <= {{WIDTH{1'b0}}, b_mag};
                        m_q <= a_mag;
                    end
`ifdef MULDIV_DIV0_TRAP_EN
                    if (is_div && b_zero)
                        div0_q <= 1'b1;
`endif
                end
                S_RUN: begin
                    p_q   <= is_div ? div_nx : mul_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        hi_q <= hi_nx;
                        lo_q <= lo_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.result = bus.hi_lo_sl ? hi_q : lo_q;

`ifdef MULDIV_DIV0_TRAP_EN
    assign bus.div0_err = div0_q;
`else
    assign bus.div0_err = 1'b0;
`endif
endmodule

// File: tb/tb_mips16_muldiv_unit.sv
// Directed-vector bench for mips16_muldiv_unit.
// Cycle 0 is the cycle in which start is high; outputs sampled on the falling edge.
module tb_mips16_muldiv_unit;
    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   rdy_abs;
    int   first_abs;

    mips16_muldiv_unit_if #(.WIDTH(16)) bus ();

    mips16_muldiv_unit #(
        .WIDTH(16),
        .CNT_W(5)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [15:0] a, input logic [15:0] b,
                          input int exp_cyc, input logic [15:0] exp_hi,
                          input logic [15:0] exp_lo, input int ign);
        int   rc;
        logic st0, b1, st_r, b_r;
        rc   = -1;
        b1   = 1'b0;
        st_r = 1'b1;
        b_r  = 1'b1;
        @(posedge clock);
        #1;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.hi_lo_sl = 1'b0;
        @(negedge clock);
        st0 = bus.instr_stall_sl;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            bus.start = (c == ign);
            if (c == ign) begin
                bus.src_a = 16'd9;
                bus.src_b = 16'd3;
            end
            @(negedge clock);
            if (c == 1)
                b1 = bus.busy;
            if (bus.ready) begin
                rc      = c;
                st_r    = bus.instr_stall_sl;
                b_r     = bus.busy;
                rdy_abs = cyc;
                break;
            end
        end
        check({tag, ".rdy_cyc"}, rc, exp_cyc);
        check({tag, ".stall0"}, {31'd0, st0}, 32'd1);
        check({tag, ".busy1"}, {31'd0, b1}, 32'd1);
        check({tag, ".stall_rdy"}, {31'd0, st_r}, 32'd0);
        check({tag, ".busy_rdy"}, {31'd0, b_r}, 32'd0);
        check({tag, ".hi"}, {16'd0, bus.hi}, {16'd0, exp_hi});
        check({tag, ".lo"}, {16'd0, bus.lo}, {16'd0, exp_lo});
        check({tag, ".res_lo"}, {16'd0, bus.result}, {16'd0, exp_lo});
    endtask

    initial begin
        int nrdy;
        n_chk        = 0;
        n_pass       = 0;
        cyc          = 0;
        rdy_abs      = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.hi_lo_sl = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.ready", {31'd0, bus.ready}, 32'd0);
        check("rst.hi", {16'd0, bus.hi}, 32'd0);
        check("rst.lo", {16'd0, bus.lo}, 32'd0);
        check("rst.div0", {31'd0, bus.div0_err}, 32'd0);
        reset_n = 1'b1;

        run_op("multu_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 18,
               16'hFFFE, 16'h0001, 0);
        run_op("mult_m3x5", 2'b00, 16'hFFFD, 16'h0005, 18,
               16'hFFFF, 16'hFFF1, 0);
        run_op("div_m7d2", 2'b10, 16'hFFF9, 16'h0002, 18,
               16'hFFFF, 16'hFFFD, 0);
        #1 bus.hi_lo_sl = 1'b1;
        #1 check("sel.hi", {16'd0, bus.result}, 32'h0000FFFF);
        bus.hi_lo_sl = 1'b0;
        #1 check("sel.lo", {16'd0, bus.result}, 32'h0000FFFD);

        run_op("mult_min", 2'b00, 16'h8000, 16'h8000, 18,
               16'h4000, 16'h0000, 0);
        run_op("div_wrap", 2'b10, 16'h8000, 16'hFFFF, 18,
               16'h0000, 16'h8000, 0);

        run_op("divu_100_7", 2'b11, 16'd100, 16'd7, 18,
               16'h0002, 16'h000E, 5);
        nrdy = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (bus.ready)
                nrdy++;
        end
        check("ign.no_rdy", nrdy, 0);
        check("ign.hi", {16'd0, bus.hi}, 32'h0002);
        check("ign.lo", {16'd0, bus.lo}, 32'h000E);

`ifdef MULDIV_DIV0_TRAP_EN
        run_op("divu_z", 2'b11, 16'h1234, 16'h0000, 2,
               16'h0002, 16'h000E, 0);
        check("divu_z.err", {31'd0, bus.div0_err}, 32'd1);
`else
        run_op("divu_z", 2'b11, 16'h1234, 16'h0000, 18,
               16'h1234, 16'hFFFF, 0);
        check("divu_z.err", {31'd0, bus.div0_err}, 32'd0);
`endif
        run_op("div_7dm2", 2'b10, 16'h0007, 16'hFFFE, 18,
               16'h0001, 16'hFFFD, 0);
        check("div0.clr", {31'd0, bus.div0_err}, 32'd0);

        @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 16'd100;
        bus.src_b = 16'd200;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.ready", {31'd0, bus.ready}, 32'd0);
        check("abort.stall", {31'd0, bus.instr_stall_sl}, 32'd0);
        check("abort.hi", {16'd0, bus.hi}, 32'd0);
        check("abort.lo", {16'd0, bus.lo}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("mult_after", 2'b00, 16'd3, 16'd4, 18,
               16'h0000, 16'h000C, 0);

        run_op("b2b_mult", 2'b00, 16'd7, 16'hFFFE, 18,
               16'hFFFF, 16'hFFF2, 0);
        first_abs = rdy_abs;
        run_op("b2b_multu", 2'b01, 16'h1234, 16'h0010, 18,
               16'h0001, 16'h2340, 0);
        check("b2b.gap", rdy_abs - first_abs, 19);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
